// File: rtl/otter_fetch_queue_pkg.sv
// Shared OTTER fetch types and constants.
// fetch_entry_t is the {pc, ir} record that the fetch queue buffers.
package otter_fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] OTTER_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
  } fetch_entry_t;

  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpImm    = 7'b0010011,
    OpReg    = 7'b0110011,
    OpSys    = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Fetch-stage bus: redirect input, instruction-memory port 1 and the decode handshake.
// master = fetch queue, slave = memory/decode side.
interface otter_fetch_queue_if #(
  parameter int unsigned Xlen  = 32,
  parameter int unsigned AddrW = 14
);
  logic            redirect;
  logic [Xlen-1:0] redirect_pc;
  logic            mem_rden1;
  logic [AddrW-1:0] mem_addr1;
  logic [31:0]     mem_dout1;
  logic            de_valid;
  logic            de_ready;
  logic [31:0]     de_ir;
  logic [Xlen-1:0] de_pc;
  logic [Xlen-1:0] de_pc_inc;

  modport master (
    input  redirect, redirect_pc, mem_dout1, de_ready,
    output mem_rden1, mem_addr1, de_valid, de_ir, de_pc, de_pc_inc
  );

  modport slave (
    output redirect, redirect_pc, mem_dout1, de_ready,
    input  mem_rden1, mem_addr1, de_valid, de_ir, de_pc, de_pc_inc
  );
endinterface

// File: rtl/otter_fetch_queue_fifo.sv
// Synchronous FIFO with power-of-two depth, naturally wrapping pointers and a
// synchronous clear that wins over push/pop.
module otter_fetch_queue_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && full_o && !clear_i));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && empty_o && !clear_i));

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER instruction-fetch stage: owns the fetch PC, issues reads on memory port 1 and
// queues {pc, ir} for decode. Define OTTER_FETCH_PERF_EN to add fetch/flush counters.
module otter_fetch_queue
  import otter_fetch_queue_pkg::*;
#(
  parameter int unsigned     Xlen    = XLEN,
  parameter int unsigned     Depth   = 4,
  parameter int unsigned     AddrW   = 14,
  parameter logic [Xlen-1:0] ResetPc = Xlen'(OTTER_RESET_PC)
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef OTTER_FETCH_PERF_EN
  output logic [31:0]         perf_fetched_o,
  output logic [31:0]         perf_flushed_o,
`endif
  otter_fetch_queue_if.master bus
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = Xlen + 32;

  logic [Xlen-1:0]   fpc_q, fpc_d, inflight_pc_q, inflight_pc_d, issue_pc, de_pc;
  logic              inflight_q, inflight_d;
  logic              issue, push, pop, de_valid;
  logic              fifo_empty, fifo_full;
  logic [CntW-1:0]   count;
  logic [EntryW-1:0] head;

  // An issue reserves a queue slot, so count+inflight bounds the queue; redirect always issues.
  always_comb begin
    issue    = !rst_i && (bus.redirect || ((int'(count) + int'(inflight_q)) < int'(Depth)));
    issue_pc = bus.redirect ? (bus.redirect_pc & ~Xlen'(3)) : fpc_q;
    push     = !rst_i && !bus.redirect && inflight_q;
    de_valid = !rst_i && !bus.redirect && !fifo_empty;
    pop      = de_valid && bus.de_ready;
    fpc_d         = issue ? issue_pc + Xlen'(4) : fpc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? issue_pc : inflight_pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc_q         <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  otter_fetch_queue_fifo #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.redirect),
    .push_i  (push),
    .data_i  ({inflight_pc_q, bus.mem_dout1}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    de_pc         = de_valid ? head[EntryW-1:32] : '0;
    bus.mem_rden1 = issue;
    bus.mem_addr1 = rst_i ? '0 : issue_pc[AddrW+1:2];
    bus.de_valid  = de_valid;
    bus.de_ir     = de_valid ? head[31:0] : '0;
    bus.de_pc     = de_pc;
    bus.de_pc_inc = rst_i ? '0 : de_pc + Xlen'(4);
  end

  a_slot_reserved: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop));

`ifdef OTTER_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;

  // Flushed counts both discarded queue entries and the dropped in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (bus.redirect) perf_flushed_q <= perf_flushed_q + 32'(count) + 32'(inflight_q);
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flushed_o = perf_flushed_q;
`endif

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Bench for otter_fetch_queue: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations. Honours OTTER_FETCH_PERF_EN.
module tb_otter_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  otter_fetch_queue_if #(.Xlen(32), .AddrW(14)) bus ();

`ifdef OTTER_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  otter_fetch_queue #(
    .Xlen    (32),
    .Depth   (4),
    .AddrW   (14),
    .ResetPc (32'h0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
`ifdef OTTER_FETCH_PERF_EN
    .perf_fetched_o (perf_fetched),
    .perf_flushed_o (perf_flushed),
`endif
    .bus            (bus)
  );

  // Memory: word[i] = 0x1000_0000 + i, one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.mem_rden1) bus.mem_dout1 <= 32'h1000_0000 + 32'(bus.mem_addr1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, ir}, fetch PC, pending read, counters.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc, m_pend_pc, m_fetched, m_flushed;
  bit          m_pend;

  task automatic m_reset();
    mq.delete();
    m_fpc     = 32'h0;
    m_pend    = 1'b0;
    m_pend_pc = 32'h0;
    m_fetched = 32'h0;
    m_flushed = 32'h0;
  endtask

  initial begin : compare
    bit          exp_valid, exp_rden;
    logic [31:0] ipc;
    ent_t        e;
    m_reset();
    forever begin
      @(negedge clk);
      exp_valid = !rst && !bus.redirect && (mq.size() > 0);
      exp_rden  = !rst && (bus.redirect || (mq.size() + int'(m_pend) < 4));
      ipc       = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : m_fpc;
      check("rden", 64'(bus.mem_rden1), 64'(exp_rden));
      check("valid", 64'(bus.de_valid), 64'(exp_valid));
      if (exp_rden) check("addr", 64'(bus.mem_addr1), 64'(ipc[15:2]));
      if (exp_valid) begin
        check("de_pc", 64'(bus.de_pc), 64'(mq[0].pc));
        check("de_ir", 64'(bus.de_ir), 64'(mq[0].ir));
        check("de_pc_inc", 64'(bus.de_pc_inc), 64'(mq[0].pc + 32'd4));
      end else begin
        check("de_pc_idle", 64'(bus.de_pc), 64'h0);
        check("de_ir_idle", 64'(bus.de_ir), 64'h0);
      end
      if (rst) check("pc_inc_rst", 64'(bus.de_pc_inc), 64'h0);
`ifdef OTTER_FETCH_PERF_EN
      check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
      check("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
      if (rst) begin
        m_reset();
      end else begin
        if (bus.redirect) begin
          m_flushed = m_flushed + 32'(mq.size()) + 32'(m_pend);
          mq.delete();
        end else begin
          if (exp_valid && bus.de_ready) void'(mq.pop_front());
          if (m_pend) begin
            e.pc = m_pend_pc;
            e.ir = 32'h1000_0000 + 32'(m_pend_pc[15:2]);
            mq.push_back(e);
            m_fetched = m_fetched + 32'd1;
          end
        end
        m_pend = exp_rden;
        if (exp_rden) begin
          m_pend_pc = ipc;
          m_fpc     = ipc + 32'd4;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin : stim
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.de_ready    = 1'b1;
    next();
    next();
    at_neg();
    check("rst_rden", 64'(bus.mem_rden1), 64'h0);
    check("rst_valid", 64'(bus.de_valid), 64'h0);

    // 1: reset release, first instruction at cycle 2, then streaming.
    next();
    rst = 1'b0;
    at_neg();
    check("t1_c0_rden", 64'(bus.mem_rden1), 64'h1);
    check("t1_c0_addr", 64'(bus.mem_addr1), 64'h0);
    next();
    at_neg();
    check("t1_c1_valid", 64'(bus.de_valid), 64'h0);
    next();
    at_neg();
    check("t1_c2_valid", 64'(bus.de_valid), 64'h1);
    check("t1_c2_pc", 64'(bus.de_pc), 64'h0);
    check("t1_c2_ir", 64'(bus.de_ir), 64'h1000_0000);
    check("t1_c2_inc", 64'(bus.de_pc_inc), 64'h4);
    for (int i = 1; i < 4; i++) begin
      next();
      at_neg();
      check("t1_stream_pc", 64'(bus.de_pc), 64'(4 * i));
      check("t1_stream_ir", 64'(bus.de_ir), 64'(32'h1000_0000 + i));
    end

    // 2: stall from reset, queue fills, then drains in order.
    next();
    rst = 1'b1;
    next();
    rst          = 1'b0;
    bus.de_ready = 1'b0;
    repeat (10) next();
    at_neg();
    check("t2_full_rden", 64'(bus.mem_rden1), 64'h0);
    check("t2_full_valid", 64'(bus.de_valid), 64'h1);
    next();
    bus.de_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("t2_drain_pc", 64'(bus.de_pc), 64'(4 * i));
      next();
    end

    // 3: redirect while full.
    bus.de_ready = 1'b0;
    repeat (6) next();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    at_neg();
    check("t3_valid", 64'(bus.de_valid), 64'h0);
    check("t3_rden", 64'(bus.mem_rden1), 64'h1);
    check("t3_addr", 64'(bus.mem_addr1), 64'd16);
    next();
    bus.redirect = 1'b0;
    bus.de_ready = 1'b1;
    at_neg();
    check("t3_r1_valid", 64'(bus.de_valid), 64'h0);
`ifdef OTTER_FETCH_PERF_EN
    check("t3_flushed", 64'(perf_flushed), 64'd4);
`endif
    next();
    at_neg();
    check("t3_r2_valid", 64'(bus.de_valid), 64'h1);
    check("t3_r2_pc", 64'(bus.de_pc), 64'h40);
    check("t3_r2_ir", 64'(bus.de_ir), 64'h1000_0010);

    // 4: back-to-back redirects, last one wins.
    next();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h80;
    next();
    bus.redirect_pc = 32'hC0;
    next();
    bus.redirect = 1'b0;
    at_neg();
    check("t4_r1_valid", 64'(bus.de_valid), 64'h0);
    next();
    at_neg();
    check("t4_pc", 64'(bus.de_pc), 64'hC0);
    check("t4_ir", 64'(bus.de_ir), 64'h1000_0030);
    next();
    at_neg();
    check("t4_pc_next", 64'(bus.de_pc), 64'hC4);

    // 6: flush of 3 queued entries plus one in flight.
    next();
    rst          = 1'b1;
    bus.de_ready = 1'b0;
    next();
    rst             = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    next();
    bus.redirect = 1'b0;
    next();
    next();
    next();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    next();
    bus.redirect = 1'b0;
    bus.de_ready = 1'b1;
    at_neg();
`ifdef OTTER_FETCH_PERF_EN
    check("t6_flushed", 64'(perf_flushed), 64'd4);
    check("t6_fetched", 64'(perf_fetched), 64'd3);
`endif
    next();
    at_neg();
    check("t6_pc", 64'(bus.de_pc), 64'h200);

    // 5: reset mid-stream overrides a simultaneous redirect.
    repeat (3) next();
    rst             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    at_neg();
    check("t5_rden", 64'(bus.mem_rden1), 64'h0);
    check("t5_valid", 64'(bus.de_valid), 64'h0);
    check("t5_ir", 64'(bus.de_ir), 64'h0);
    check("t5_pc", 64'(bus.de_pc), 64'h0);
    check("t5_inc", 64'(bus.de_pc_inc), 64'h0);
    next();
    rst          = 1'b0;
    bus.redirect = 1'b0;
    at_neg();
    check("t5_c0_rden", 64'(bus.mem_rden1), 64'h1);
    check("t5_c0_addr", 64'(bus.mem_addr1), 64'h0);
    next();
    next();
    at_neg();
    check("t5_c2_pc", 64'(bus.de_pc), 64'h0);
    check("t5_c2_ir", 64'(bus.de_ir), 64'h1000_0000);

    repeat (3) next();
    at_neg();
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
